dual_slope_ctrl: RTL and testbench

Control sequencer for the dual-slope ADC. It drives the integrator switches (Vin run-up, Vref run-down, integrator discharge) and times a fixed N_INT-cycle run-up. It then counts run-down cycles until the synchronised comparator falls, and presents the count as the conversion result through a valid/ready handshake. It sits between the analog front-end (integrator plus comparator) and the digital consumer of conversion codes.

---
 rtl/dsadc_pkg.sv | 16 +
 rtl/dual_slope_ctrl_phase_timer.sv | 38 +++
 rtl/dual_slope_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dsadc_pkg.sv
// Shared types and default sizing for the dual-slope ADC control sequencer.
package dsadc_pkg;

    localparam int DSADC_WIDTH       = 4;
    localparam int DSADC_N_INT       = 10;
    localparam int DSADC_ZERO_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ZERO     = 3'd1,
        RUN_UP   = 3'd2,
        RUN_DOWN = 3'd3,
        HOLD     = 3'd4
    } dsadc_state_e;

endpackage

// File: rtl/dual_slope_ctrl_phase_timer.sv
// Phase counter shared by the auto-zero, run-up and run-down phases:
// synchronous clear, enable, and a count == limit flag. Holds at all-ones.
module phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == limit);

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed run-up, timed run-down, result handshake.
// Define DSADC_AUTOZERO_EN to insert the ZERO (integrator discharge) phase after start.
module dual_slope_ctrl
    import dsadc_pkg::*;
#(
    parameter int WIDTH       = DSADC_WIDTH,
    parameter int N_INT       = DSADC_N_INT,
    parameter int ZERO_CYCLES = DSADC_ZERO_CYCLES
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             start,
    input  logic             cmp,
    output logic             sw_vin,
    output logic             sw_vref,
    output logic             int_rst,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam logic [WIDTH-1:0] ZERO_LIMIT   = WIDTH'(ZERO_CYCLES - 1);
    localparam logic [WIDTH-1:0] RUN_UP_LIMIT = WIDTH'(N_INT - 1);
    localparam logic [WIDTH-1:0] SAT_LIMIT    = {WIDTH{1'b1}};

`ifdef DSADC_AUTOZERO_EN
    localparam dsadc_state_e START_STATE = ZERO;
`else
    localparam dsadc_state_e START_STATE = RUN_UP;
`endif

    dsadc_state_e     state_q, state_d;
    logic             cmp_meta_q, cmp_s_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             sw_vin_q, sw_vin_d;
    logic             sw_vref_q, sw_vref_d;
    logic             int_rst_q, int_rst_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;

    logic             tmr_clr;
    logic             tmr_en;
    logic [WIDTH-1:0] tmr_limit;
    logic [WIDTH-1:0] tmr_count;
    logic             tmr_at_limit;

    phase_timer #(
        .WIDTH(WIDTH)
    ) u_phase_timer (
        .clk      (clk),
        .rst_s    (rst_s),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .limit    (tmr_limit),
        .count    (tmr_count),
        .at_limit (tmr_at_limit)
    );

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_limit  = ZERO_LIMIT;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START_STATE;
                    tmr_clr = 1'b1;
                end
            end
`ifdef DSADC_AUTOZERO_EN
            ZERO: begin
                if (tmr_at_limit) begin
                    state_d = RUN_UP;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
`endif
            RUN_UP: begin
                tmr_limit = RUN_UP_LIMIT;
                if (tmr_at_limit) begin
                    state_d = RUN_DOWN;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RUN_DOWN: begin
                // Comparator crossing wins over saturation on the same cycle.
                tmr_limit = SAT_LIMIT;
                if (!cmp_s_q) begin
                    result_d   = tmr_count;
                    overflow_d = 1'b0;
                    state_d    = HOLD;
                    tmr_clr    = 1'b1;
                end else if (tmr_at_limit) begin
                    result_d   = SAT_LIMIT;
                    overflow_d = 1'b1;
                    state_d    = HOLD;
                    tmr_clr    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies track state_q.
        sw_vin_d       = (state_d == RUN_UP);
        sw_vref_d      = (state_d == RUN_DOWN);
        int_rst_d      = (state_d == IDLE) || (state_d == ZERO);
        busy_d         = (state_d != IDLE);
        result_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q        <= IDLE;
            cmp_meta_q     <= 1'b0;
            cmp_s_q        <= 1'b0;
            result_q       <= '0;
            overflow_q     <= 1'b0;
            sw_vin_q       <= 1'b0;
            sw_vref_q      <= 1'b0;
            int_rst_q      <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmp_meta_q     <= cmp;
            cmp_s_q        <= cmp_meta_q;
            result_q       <= result_d;
            overflow_q     <= overflow_d;
            sw_vin_q       <= sw_vin_d;
            sw_vref_q      <= sw_vref_d;
            int_rst_q      <= int_rst_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign sw_vin       = sw_vin_q;
    assign sw_vref      = sw_vref_q;
    assign int_rst      = int_rst_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed self-checking bench for dual_slope_ctrl; expectations follow DSADC_AUTOZERO_EN.
module tb_dual_slope_ctrl;

`ifdef DSADC_AUTOZERO_EN
    localparam int ZC = 3;
`else
    localparam int ZC = 0;
`endif
    localparam int NI = 10;

    logic       clk = 1'b0;
    logic       rst_s;
    logic       start;
    logic       cmp;
    logic       sw_vin;
    logic       sw_vref;
    logic       int_rst;
    logic       busy;
    logic [3:0] result;
    logic       overflow;
    logic       result_valid;
    logic       result_ready;

    int checks = 0;
    int errors = 0;

    int   zero_cnt, vin_cnt, vref_cnt, rv_cnt, busy_cnt;
    int   first_vin, first_rv, last_rv;
    logic [3:0] res_first;
    logic ovf_first;
    bit   res_stable;
    logic end_busy;
    logic end_int_rst;

    dual_slope_ctrl dut (
        .clk          (clk),
        .rst_s        (rst_s),
        .start        (start),
        .cmp          (cmp),
        .sw_vin       (sw_vin),
        .sw_vref      (sw_vref),
        .int_rst      (int_rst),
        .busy         (busy),
        .result       (result),
        .overflow     (overflow),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One conversion. cmp drops to 0 for the edge after negedge number dropN
    // (counted from the start edge); HOLD is back-pressured for readyDelay cycles.
    task automatic applyStimulus(input int dropN, input int readyDelay, input bit poke);
        int k;
        zero_cnt = 0; vin_cnt = 0; vref_cnt = 0; rv_cnt = 0; busy_cnt = 0;
        first_vin = 0; first_rv = 0; last_rv = 0;
        res_first = '0; ovf_first = 1'b0; res_stable = 1'b1;
        k = 0;
        result_ready = 1'b0;
        cmp = (dropN > 1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (busy === 1'b1 && int_rst === 1'b1) zero_cnt++;
            if (sw_vin === 1'b1) begin
                vin_cnt++;
                if (first_vin == 0) first_vin = n;
            end
            if (sw_vref === 1'b1) vref_cnt++;
            if (result_valid === 1'b1) begin
                rv_cnt++;
                k++;
                last_rv = n;
                if (k == 1) begin
                    first_rv  = n;
                    res_first = result;
                    ovf_first = overflow;
                end else if (result !== res_first || overflow !== ovf_first) begin
                    res_stable = 1'b0;
                end
            end
            cmp          = (n < dropN);
            result_ready = (k > readyDelay);
            start        = poke && ((n == ZC + 3) || (k == 2));
        end
        end_busy    = busy;
        end_int_rst = int_rst;
    endtask

    initial begin
        rst_s = 1'b1; start = 1'b0; cmp = 1'b0; result_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_int_rst", int_rst, 1);
        checkOutput("rst_sw_vin", sw_vin, 0);
        checkOutput("rst_sw_vref", sw_vref, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_result_valid", result_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_overflow", overflow, 0);
        rst_s = 1'b0;
        @(negedge clk);

        $display("[TB] nominal conversion, result 5");
        applyStimulus(ZC + NI + 5 - 1, 0, 1'b0);
        checkOutput("nom_zero_cycles", zero_cnt, ZC);
        checkOutput("nom_first_vin", first_vin, ZC + 1);
        checkOutput("nom_vin_cycles", vin_cnt, NI);
        checkOutput("nom_vref_cycles", vref_cnt, 6);
        checkOutput("nom_latency", first_rv, ZC + NI + 5 + 2);
        checkOutput("nom_result", res_first, 5);
        checkOutput("nom_overflow", ovf_first, 0);
        checkOutput("nom_valid_cycles", rv_cnt, 1);
        checkOutput("nom_busy_cycles", busy_cnt, ZC + NI + 6 + 1);
        checkOutput("nom_end_idle", end_busy, 0);
        checkOutput("nom_end_int_rst", end_int_rst, 1);

        $display("[TB] overflow, cmp stuck high");
        applyStimulus(1000, 0, 1'b0);
        checkOutput("ovf_vref_cycles", vref_cnt, 16);
        checkOutput("ovf_result", res_first, 15);
        checkOutput("ovf_overflow", ovf_first, 1);
        checkOutput("ovf_latency", first_rv, ZC + NI + 15 + 2);

        $display("[TB] zero input, cmp low throughout");
        applyStimulus(0, 0, 1'b0);
        checkOutput("zero_vref_cycles", vref_cnt, 1);
        checkOutput("zero_result", res_first, 0);
        checkOutput("zero_overflow", ovf_first, 0);
        checkOutput("zero_latency", first_rv, ZC + NI + 2);

        $display("[TB] back-pressure with ignored start pulses, result 3");
        applyStimulus(ZC + NI + 3 - 1, 5, 1'b1);
        checkOutput("bp_result", res_first, 3);
        checkOutput("bp_overflow", ovf_first, 0);
        checkOutput("bp_valid_cycles", rv_cnt, 6);
        checkOutput("bp_valid_contiguous", last_rv - first_rv + 1, 6);
        checkOutput("bp_result_stable", res_stable, 1);
        checkOutput("bp_busy_cycles", busy_cnt, ZC + NI + 4 + 6);
        checkOutput("bp_vin_cycles", vin_cnt, NI);
        checkOutput("bp_end_idle", end_busy, 0);

        $display("[TB] asynchronous reset during run-down");
        cmp = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ZC + NI + 2) @(negedge clk);
        checkOutput("mid_sw_vref_before", sw_vref, 1);
        checkOutput("mid_result_before", result, 3);
        #2 rst_s = 1'b1;
        #1;
        checkOutput("mid_sw_vref", sw_vref, 0);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_result", result, 0);
        checkOutput("mid_int_rst", int_rst, 1);
        checkOutput("mid_result_valid", result_valid, 0);
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);

        $display("[TB] clean conversion after reset");
        applyStimulus(ZC + NI + 5 - 1, 0, 1'b0);
        checkOutput("post_rst_result", res_first, 5);
        checkOutput("post_rst_overflow", ovf_first, 0);
        checkOutput("post_rst_latency", first_rv, ZC + NI + 5 + 2);
        checkOutput("post_rst_vin_cycles", vin_cnt, NI);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
